pkt_buf_ctrl: RTL and testbench

Parametrised successor of the single-region packet copy buffer. Stores received MAC frames, byte stream after SFD, into a circular dual-port RAM. Commits only frames that are error-free, within the length bounds, and fit in the buffer. Drops everything else with a rollback and a per-cause saturating counter. Sits between the RX frame FSM and the switching/forwarding logic, and presents committed packets as a SOP/EOP-framed byte stream with the length known up front.

---
 rtl/pkt_buf_ctrl_pkg.sv | 24 ++
 rtl/fifo.sv | 41 ++++
 rtl/pkt_buf_rd_ctrl.sv | 85 ++++++++
 rtl/sram.sv | 21 ++
 rtl/pkt_buf_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pkt_buf_ctrl.sv | 277 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/pkt_buf_ctrl_pkg.sv
// Shared definitions for the packet buffer controller.
// Holds the RX frame FSM encoding that marks the SFD cycle and the
// write/read FSM state encodings used by the buffer.
package pkt_buf_ctrl_pkg;

  // RX frame FSM state bus, shared with the RX FSM
  localparam int pFSM_BUS_WIDTH = 3;
  localparam logic [pFSM_BUS_WIDTH-1:0] lpSFD = 3'd2;

  localparam int lpWR_STATE_WIDTH = 2;
  typedef enum logic [lpWR_STATE_WIDTH-1:0] {
    WR_IDLE   = 2'd0,
    WR_DATA   = 2'd1,
    WR_COMMIT = 2'd2,
    WR_DROP   = 2'd3
  } wr_state_t;

  localparam int lpRD_STATE_WIDTH = 1;
  typedef enum logic [lpRD_STATE_WIDTH-1:0] {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_t;

endpackage

// File: rtl/fifo.sv
// Synchronous show-ahead FIFO (o_rdata is the head entry while !o_empty).
// Ports: i_push/i_wdata write, i_pop read, o_full/o_empty status.
module fifo #(
  parameter int pWIDTH = 8,
  parameter int pDEPTH = 16
) (
  input  logic              iclk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [pWIDTH-1:0] i_wdata,
  input  logic              i_pop,
  output logic [pWIDTH-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty
);
  localparam int lpAW = $clog2(pDEPTH);

  logic [pWIDTH-1:0] r_mem [pDEPTH];
  logic [lpAW:0]     r_wp, r_rp;
  logic              w_do_push, w_do_pop;

  assign o_empty   = (r_wp == r_rp);
  assign o_full    = (r_wp[lpAW] != r_rp[lpAW]) && (r_wp[lpAW-1:0] == r_rp[lpAW-1:0]);
  assign o_rdata   = r_mem[r_rp[lpAW-1:0]];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge iclk) begin
    if (w_do_push) r_mem[r_wp[lpAW-1:0]] <= i_wdata;
  end

  always_ff @(posedge iclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + 1'b1;
      if (w_do_pop)  r_rp <= r_rp + 1'b1;
    end
  end
endmodule

// File: rtl/pkt_buf_rd_ctrl.sv
// Read side of the packet buffer: pops length descriptors, walks the read
// pointer through committed data and frames the output with SOP/EOP.
// Ports: descriptor FIFO handshake, RAM read address/enable, read
// success pointer back to the top, and the registered valid/sop/eop/len.
//
// state   | meaning
// RD_IDLE | waiting for a descriptor; pops it and loads the length
// RD_DATA | issuing RAM reads on i_rd_en until the length is exhausted
module pkt_buf_rd_ctrl
  import pkt_buf_ctrl_pkg::*;
#(
  parameter int pLEN_WIDTH = 11,
  parameter int pAW        = 12
) (
  input  logic                  iclk,
  input  logic                  i_rst_n,
  input  logic                  i_desc_empty,
  input  logic [pLEN_WIDTH-1:0] i_desc_len,
  input  logic                  i_rd_en,
  output logic                  o_desc_pop,
  output logic                  o_ram_re,
  output logic [pAW-1:0]        o_ram_addr,
  output logic [pAW:0]          o_rd_succ,
  output logic                  o_valid,
  output logic                  o_sop,
  output logic                  o_eop,
  output logic [pLEN_WIDTH-1:0] o_len,
  output logic                  o_pkt_avail
);
  rd_state_t             r_state;
  logic [pAW:0]          r_rd_now;
  logic [pLEN_WIDTH-1:0] r_cnt;
  logic                  r_first;
  logic                  w_last;

  assign o_desc_pop  = (r_state == RD_IDLE) & ~i_desc_empty;
  assign o_ram_re    = (r_state == RD_DATA) & i_rd_en;
  assign o_ram_addr  = r_rd_now[pAW-1:0];
  assign o_pkt_avail = ~i_desc_empty | (r_state == RD_DATA);
  assign w_last      = (r_cnt == pLEN_WIDTH'(1));

  always_ff @(posedge iclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= RD_IDLE;
      r_rd_now  <= '0;
      o_rd_succ <= '0;
      r_cnt     <= '0;
      r_first   <= 1'b0;
      o_valid   <= 1'b0;
      o_sop     <= 1'b0;
      o_eop     <= 1'b0;
      o_len     <= '0;
    end else begin
      // valid/sop/eop are the registered issue, so they align with RAM data
      o_valid <= 1'b0;
      o_sop   <= 1'b0;
      o_eop   <= 1'b0;
      case (r_state)
        RD_IDLE: begin
          if (!i_desc_empty) begin
            o_len   <= i_desc_len;
            r_cnt   <= i_desc_len;
            r_first <= 1'b1;
            r_state <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (i_rd_en) begin
            o_valid  <= 1'b1;
            o_sop    <= r_first;
            o_eop    <= w_last;
            r_first  <= 1'b0;
            r_rd_now <= r_rd_now + 1'b1;
            r_cnt    <= r_cnt - 1'b1;
            if (w_last) begin
              o_rd_succ <= r_rd_now + 1'b1;
              r_state   <= RD_IDLE;
            end
          end
        end
        default: r_state <= RD_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/sram.sv
// Simple dual-port RAM, one write port, one read port, read latency 1.
// Ports: i_we/i_waddr/i_wdata write, i_re/i_raddr read, o_rdata data.
module sram #(
  parameter int pWIDTH = 8,
  parameter int pDEPTH = 4096
) (
  input  logic                      iclk,
  input  logic                      i_we,
  input  logic [$clog2(pDEPTH)-1:0] i_waddr,
  input  logic [pWIDTH-1:0]         i_wdata,
  input  logic                      i_re,
  input  logic [$clog2(pDEPTH)-1:0] i_raddr,
  output logic [pWIDTH-1:0]         o_rdata
);
  logic [pWIDTH-1:0] r_mem [pDEPTH];

  always_ff @(posedge iclk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/pkt_buf_ctrl.sv
// Packet buffer controller: stores received frames in a circular RAM,
// commits only good frames within length bounds that fit, rolls back and
// counts the rest, and streams committed packets out with SOP/EOP.
// Ports: RX side (idv/irx_d/irx_er/iframe_state), consumer read request
// ird_en, read stream (or_data/ovalid/osop/oeop/olen_pac), status
// (opkt_avail/ofull/ofree) and saturating drop counters.
//
// state     | meaning
// WR_IDLE   | waiting for SFD with data valid
// WR_DATA   | storing frame bytes at wr_now
// WR_COMMIT | push length descriptor, advance wr_succ
// WR_DROP   | wait for end of frame, roll wr_now back to wr_succ
module pkt_buf_ctrl
  import pkt_buf_ctrl_pkg::*;
#(
  parameter int pDATA_WIDTH        = 8,
  parameter int pMIN_PACKET_LENGTH = 64,
  parameter int pMAX_PACKET_LENGTH = 1536,
  parameter int pDEPTH_RAM         = 4096,
  parameter int pDESC_DEPTH        = 64,
  parameter int pLEN_WIDTH         = $clog2(pMAX_PACKET_LENGTH + 1),
  parameter int pCNT_WIDTH         = 16
) (
  input  logic                          iclk,
  input  logic                          i_rst_n,
  input  logic                          idv,
  input  logic [pDATA_WIDTH-1:0]        irx_d,
  input  logic                          irx_er,
  input  logic [pFSM_BUS_WIDTH-1:0]     iframe_state,
  input  logic                          ird_en,
  output logic [pDATA_WIDTH-1:0]        or_data,
  output logic                          ovalid,
  output logic                          osop,
  output logic                          oeop,
  output logic [pLEN_WIDTH-1:0]         olen_pac,
  output logic                          opkt_avail,
  output logic                          ofull,
  output logic [$clog2(pDEPTH_RAM):0]   ofree,
  output logic [pCNT_WIDTH-1:0]         odrop_err,
  output logic [pCNT_WIDTH-1:0]         odrop_len,
  output logic [pCNT_WIDTH-1:0]         odrop_ovf
);
  localparam int lpAW = $clog2(pDEPTH_RAM);
  localparam int lpPW = lpAW + 1;

  wr_state_t             r_wr_state;
  logic [lpPW-1:0]       r_wr_now, r_wr_succ;
  logic [pLEN_WIDTH-1:0] r_len;

  logic [lpPW-1:0]        w_rd_succ, w_used;
  logic                   w_desc_full, w_desc_empty, w_desc_pop, w_desc_push;
  logic [pLEN_WIDTH-1:0]  w_desc_len;
  logic                   w_start, w_len_max, w_space_full, w_ram_we, w_ram_re;
  logic [lpAW-1:0]        w_ram_raddr;
  logic [pDATA_WIDTH-1:0] w_ram_q;
  logic                   w_valid;

  // the extra pointer bit distinguishes a full buffer from an empty one
  assign w_used       = r_wr_now - w_rd_succ;
  assign ofree        = lpPW'(pDEPTH_RAM) - w_used;
  assign ofull        = (ofree < lpPW'(pMAX_PACKET_LENGTH)) | w_desc_full;
  assign w_start      = idv & (iframe_state == lpSFD) & ~irx_er;
  assign w_len_max    = (r_len == pLEN_WIDTH'(pMAX_PACKET_LENGTH));
  assign w_space_full = (w_used == lpPW'(pDEPTH_RAM));
  assign w_ram_we     = (r_wr_state == WR_DATA) & idv & ~irx_er & ~w_len_max & ~w_space_full;
  assign w_desc_push  = (r_wr_state == WR_COMMIT);
  assign ovalid       = w_valid;
  assign or_data      = w_valid ? w_ram_q : '0;

  always_ff @(posedge iclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_state <= WR_IDLE;
      r_wr_now   <= '0;
      r_wr_succ  <= '0;
      r_len      <= '0;
      odrop_err  <= '0;
      odrop_len  <= '0;
      odrop_ovf  <= '0;
    end else begin
      case (r_wr_state)
        WR_IDLE: begin
          r_len <= '0;
          if (w_start) begin
            if (w_desc_full) begin
              r_wr_state <= WR_DROP;
              if (~&odrop_ovf) odrop_ovf <= odrop_ovf + 1'b1;
            end else begin
              r_wr_state <= WR_DATA;
            end
          end
        end
        WR_DATA: begin
          if (idv) begin
            if (irx_er) begin
              r_wr_state <= WR_DROP;
              if (~&odrop_err) odrop_err <= odrop_err + 1'b1;
            end else if (w_len_max) begin
              r_wr_state <= WR_DROP;
              if (~&odrop_len) odrop_len <= odrop_len + 1'b1;
            end else if (w_space_full) begin
              r_wr_state <= WR_DROP;
              if (~&odrop_ovf) odrop_ovf <= odrop_ovf + 1'b1;
            end else begin
              r_wr_now <= r_wr_now + 1'b1;
              r_len    <= r_len + 1'b1;
            end
          end else if (r_len < pLEN_WIDTH'(pMIN_PACKET_LENGTH)) begin
            r_wr_state <= WR_DROP;
            if (~&odrop_len) odrop_len <= odrop_len + 1'b1;
          end else begin
            r_wr_state <= WR_COMMIT;
          end
        end
        WR_COMMIT: begin
          r_wr_succ  <= r_wr_now;
          r_wr_state <= WR_IDLE;
        end
        WR_DROP: begin
          if (!idv) begin
            r_wr_now   <= r_wr_succ;
            r_wr_state <= WR_IDLE;
          end
        end
        default: r_wr_state <= WR_IDLE;
      endcase
    end
  end

  fifo #(.pWIDTH(pLEN_WIDTH), .pDEPTH(pDESC_DEPTH)) u_desc_fifo (
    .iclk    (iclk),
    .i_rst_n (i_rst_n),
    .i_push  (w_desc_push),
    .i_wdata (r_len),
    .i_pop   (w_desc_pop),
    .o_rdata (w_desc_len),
    .o_full  (w_desc_full),
    .o_empty (w_desc_empty)
  );

  sram #(.pWIDTH(pDATA_WIDTH), .pDEPTH(pDEPTH_RAM)) u_pkt_ram (
    .iclk    (iclk),
    .i_we    (w_ram_we),
    .i_waddr (r_wr_now[lpAW-1:0]),
    .i_wdata (irx_d),
    .i_re    (w_ram_re),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_ram_q)
  );

  pkt_buf_rd_ctrl #(.pLEN_WIDTH(pLEN_WIDTH), .pAW(lpAW)) u_rd_ctrl (
    .iclk        (iclk),
    .i_rst_n     (i_rst_n),
    .i_desc_empty(w_desc_empty),
    .i_desc_len  (w_desc_len),
    .i_rd_en     (ird_en),
    .o_desc_pop  (w_desc_pop),
    .o_ram_re    (w_ram_re),
    .o_ram_addr  (w_ram_raddr),
    .o_rd_succ   (w_rd_succ),
    .o_valid     (w_valid),
    .o_sop       (osop),
    .o_eop       (oeop),
    .o_len       (olen_pac),
    .o_pkt_avail (opkt_avail)
  );
endmodule

// File: tb/tb_pkt_buf_ctrl.sv
// Self-checking bench for pkt_buf_ctrl (default parameters).
// Frames expected to commit push their bytes to a scoreboard when driven;
// a negedge monitor pops and compares every output beat.
module tb_pkt_buf_ctrl;
  import pkt_buf_ctrl_pkg::*;

  localparam logic [pFSM_BUS_WIDTH-1:0] lpDATA_ST = 3'd3;

  logic        iclk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        idv = 1'b0;
  logic [7:0]  irx_d = '0;
  logic        irx_er = 1'b0;
  logic [pFSM_BUS_WIDTH-1:0] iframe_state = '0;
  logic        ird_en = 1'b0;
  logic [7:0]  or_data;
  logic        ovalid, osop, oeop, opkt_avail, ofull;
  logic [10:0] olen_pac;
  logic [12:0] ofree;
  logic [15:0] odrop_err, odrop_len, odrop_ovf;

  typedef struct {
    logic [7:0]  d;
    logic        sop;
    logic        eop;
    logic [10:0] len;
  } beat_t;

  beat_t sb[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_beats = 0, n_sop = 0, n_eop = 0;
  int exp_err = 0, exp_len = 0, exp_ovf = 0;

  always #5 iclk = ~iclk;

  pkt_buf_ctrl dut (
    .iclk(iclk), .i_rst_n(i_rst_n), .idv(idv), .irx_d(irx_d), .irx_er(irx_er),
    .iframe_state(iframe_state), .ird_en(ird_en), .or_data(or_data), .ovalid(ovalid),
    .osop(osop), .oeop(oeop), .olen_pac(olen_pac), .opkt_avail(opkt_avail),
    .ofull(ofull), .ofree(ofree), .odrop_err(odrop_err), .odrop_len(odrop_len),
    .odrop_ovf(odrop_ovf)
  );

  // output monitor / scoreboard compare
  always @(negedge iclk) begin
    beat_t e;
    if (i_rst_n && ovalid) begin
      n_beats++;
      if (osop) n_sop++;
      if (oeop) n_eop++;
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL beat_unexpected: got data=%h sop=%b eop=%b len=%0d, required no beat",
                 or_data, osop, oeop, olen_pac);
      end else begin
        e = sb.pop_front();
        if (or_data !== e.d || osop !== e.sop || oeop !== e.eop || olen_pac !== e.len) begin
          n_errors++;
          $display("FAIL beat: got data=%h sop=%b eop=%b len=%0d, required data=%h sop=%b eop=%b len=%0d",
                   or_data, osop, oeop, olen_pac, e.d, e.sop, e.eop, e.len);
        end
      end
    end
  end

  task automatic send_frame(input int n, input int err_at, input bit commit);
    beat_t e;
    logic [7:0] b;
    @(posedge iclk); #1;
    idv = 1'b1; iframe_state = lpSFD; irx_d = 8'hD5; irx_er = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge iclk); #1;
      b = 8'($urandom_range(0, 255));
      iframe_state = lpDATA_ST; irx_d = b; irx_er = (i == err_at);
      if (commit) begin
        e.d = b; e.sop = (i == 0); e.eop = (i == n - 1); e.len = 11'(n);
        sb.push_back(e);
      end
    end
    @(posedge iclk); #1;
    idv = 1'b0; irx_er = 1'b0; iframe_state = '0;
    repeat (4) @(posedge iclk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c;
    c = 0;
    while ((sb.size() != 0 || ovalid || opkt_avail) && c < budget) begin
      @(negedge iclk);
      c++;
    end
    n_checks++;
    if (c >= budget) begin
      n_errors++;
      $display("FAIL %s_drain_timeout: got %0d beats outstanding, required 0", name, sb.size());
    end
    @(posedge iclk); #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) @(posedge iclk);
    #1;
    n_checks++;
    if (ofree !== 13'd4096) begin n_errors++; $display("FAIL reset_ofree: got %0d required 4096", ofree); end
    n_checks++;
    if ({ovalid, osop, oeop, opkt_avail, ofull} !== 5'b0 || or_data !== 8'h0 || olen_pac !== 11'h0) begin
      n_errors++;
      $display("FAIL reset_outputs: got v=%b s=%b e=%b a=%b f=%b d=%h l=%0d required all 0",
               ovalid, osop, oeop, opkt_avail, ofull, or_data, olen_pac);
    end
    n_checks++;
    if ({odrop_err, odrop_len, odrop_ovf} !== 48'h0) begin
      n_errors++; $display("FAIL reset_counters: got %0d/%0d/%0d required 0", odrop_err, odrop_len, odrop_ovf);
    end
    i_rst_n = 1'b1;
    @(posedge iclk); #1;
  endtask

  task automatic test_good_frame();
    ird_en = 1'b0;
    send_frame(64, -1, 1'b1);
    n_checks++;
    if (opkt_avail !== 1'b1) begin n_errors++; $display("FAIL good_avail: got %b required 1", opkt_avail); end
    n_checks++;
    if (ofree !== 13'd4032) begin n_errors++; $display("FAIL good_ofree_held: got %0d required 4032", ofree); end
    n_beats = 0; n_sop = 0; n_eop = 0;
    ird_en = 1'b1;
    wait_drain("good", 300);
    n_checks++;
    if (n_beats != 64 || n_sop != 1 || n_eop != 1) begin
      n_errors++; $display("FAIL good_beats: got %0d/%0d/%0d required 64/1/1", n_beats, n_sop, n_eop);
    end
    n_checks++;
    if (opkt_avail !== 1'b0 || ofree !== 13'd4096) begin
      n_errors++; $display("FAIL good_release: got avail=%b free=%0d required 0/4096", opkt_avail, ofree);
    end
  endtask

  task automatic test_err_frame();
    send_frame(100, 50, 1'b0);
    exp_err++;
    n_checks++;
    if (odrop_err !== 16'(exp_err)) begin n_errors++; $display("FAIL err_cnt: got %0d required %0d", odrop_err, exp_err); end
    n_checks++;
    if (ofree !== 13'd4096 || opkt_avail !== 1'b0) begin
      n_errors++; $display("FAIL err_rollback: got free=%0d avail=%b required 4096/0", ofree, opkt_avail);
    end
    send_frame(64, -1, 1'b1);
    wait_drain("err_follow", 300);
  endtask

  task automatic test_len_bounds();
    send_frame(63, -1, 1'b0);
    send_frame(1537, -1, 1'b0);
    exp_len += 2;
    n_checks++;
    if (odrop_len !== 16'(exp_len)) begin n_errors++; $display("FAIL len_cnt: got %0d required %0d", odrop_len, exp_len); end
    n_checks++;
    if (ofree !== 13'd4096 || opkt_avail !== 1'b0 || odrop_err !== 16'(exp_err)) begin
      n_errors++; $display("FAIL len_nothing_committed: got free=%0d avail=%b err=%0d", ofree, opkt_avail, odrop_err);
    end
  endtask

  task automatic test_overflow();
    int c;
    ird_en = 1'b0;
    send_frame(1536, -1, 1'b1);
    n_checks++;
    if (ofull !== 1'b0) begin n_errors++; $display("FAIL ovf_full_one: got %b required 0", ofull); end
    send_frame(1536, -1, 1'b1);
    n_checks++;
    if (ofull !== 1'b1 || ofree !== 13'd1024) begin
      n_errors++; $display("FAIL ovf_full_two: got full=%b free=%0d required 1/1024", ofull, ofree);
    end
    send_frame(1536, -1, 1'b0);
    exp_ovf++;
    n_checks++;
    if (odrop_ovf !== 16'(exp_ovf) || ofree !== 13'd1024) begin
      n_errors++; $display("FAIL ovf_drop: got ovf=%0d free=%0d required %0d/1024", odrop_ovf, ofree, exp_ovf);
    end
    ird_en = 1'b1;
    c = 0;
    while (sb.size() > 1536 && c < 3000) begin @(negedge iclk); c++; end
    @(posedge iclk); #1;
    ird_en = 1'b0;
    n_checks++;
    if (c >= 3000) begin n_errors++; $display("FAIL ovf_read_one_timeout: got %0d left required 1536", sb.size()); end
    repeat (2) @(posedge iclk);
    #1;
    n_checks++;
    if (ofree !== 13'd2560) begin n_errors++; $display("FAIL ovf_free_after_read: got %0d required 2560", ofree); end
    send_frame(1536, -1, 1'b1);
    n_checks++;
    if (odrop_ovf !== 16'(exp_ovf)) begin n_errors++; $display("FAIL ovf_wrap_commit: got ovf=%0d required %0d", odrop_ovf, exp_ovf); end
    ird_en = 1'b1;
    wait_drain("ovf", 5000);
    n_checks++;
    if (ofree !== 13'd4096) begin n_errors++; $display("FAIL ovf_final_free: got %0d required 4096", ofree); end
  endtask

  task automatic test_rd_toggle();
    int c;
    ird_en = 1'b0;
    send_frame(64, -1, 1'b1);
    n_beats = 0; n_sop = 0; n_eop = 0;
    c = 0;
    while ((sb.size() != 0 || opkt_avail || ovalid) && c < 400) begin
      ird_en = (c % 3 != 2);
      @(posedge iclk); #1;
      c++;
    end
    ird_en = 1'b0;
    n_checks++;
    if (n_beats != 64 || n_sop != 1 || n_eop != 1 || c >= 400) begin
      n_errors++; $display("FAIL toggle_beats: got %0d/%0d/%0d required 64/1/1", n_beats, n_sop, n_eop);
    end
  endtask

  task automatic test_async_reset();
    // mid-write reset
    @(posedge iclk); #1;
    idv = 1'b1; iframe_state = lpSFD; irx_d = 8'hD5;
    for (int i = 0; i < 30; i++) begin
      @(posedge iclk); #1;
      iframe_state = lpDATA_ST; irx_d = 8'(i);
    end
    #2 i_rst_n = 1'b0;
    #1;
    n_checks++;
    if (ofree !== 13'd4096 || {odrop_err, odrop_len, odrop_ovf} !== 48'h0) begin
      n_errors++; $display("FAIL rst_write: got free=%0d cnt=%0d/%0d/%0d required 4096/0", ofree, odrop_err, odrop_len, odrop_ovf);
    end
    idv = 1'b0; iframe_state = '0;
    exp_err = 0; exp_len = 0; exp_ovf = 0;
    @(posedge iclk); #1 i_rst_n = 1'b1;
    // mid-read reset
    ird_en = 1'b1;
    send_frame(64, -1, 1'b1);
    repeat (10) @(posedge iclk);
    #2 i_rst_n = 1'b0;
    sb.delete();
    #1;
    n_checks++;
    if ({ovalid, osop, oeop, opkt_avail, ofull} !== 5'b0 || or_data !== 8'h0 ||
        olen_pac !== 11'h0 || ofree !== 13'd4096) begin
      n_errors++;
      $display("FAIL rst_read: got v=%b s=%b e=%b a=%b f=%b d=%h l=%0d free=%0d required 0s/4096",
               ovalid, osop, oeop, opkt_avail, ofull, or_data, olen_pac, ofree);
    end
    @(posedge iclk); #1 i_rst_n = 1'b1;
    n_beats = 0;
    send_frame(64, -1, 1'b1);
    wait_drain("rst_follow", 300);
    n_checks++;
    if (n_beats != 64 || ofree !== 13'd4096 || odrop_err !== 16'(exp_err)) begin
      n_errors++; $display("FAIL rst_follow: got beats=%0d free=%0d err=%0d required 64/4096/0", n_beats, ofree, odrop_err);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_err_frame();
    test_len_bounds();
    test_overflow();
    test_rd_toggle();
    test_async_reset();
    n_checks++;
    if (sb.size() != 0) begin n_errors++; $display("FAIL sb_leftover: got %0d required 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
